// File: rtl/sa_dispatcher.sv
// Systolic-array dispatcher: in-order instruction queue, accumulator
// scoreboard for RAW/WAW stalls, and a completion/commit handshake FSM.
module sa_dispatcher #(
  parameter int unsigned N_REGS       = 8,
  parameter int unsigned ID_WIDTH     = 4,
  parameter int unsigned CTRL_WIDTH   = 4,
  parameter int unsigned DEPTH        = 4,
  parameter int unsigned MAX_INFLIGHT = 3,
  localparam int unsigned REG_W       = $clog2(N_REGS)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  issue_valid_i,
  output logic                  issue_ready_o,
  input  logic [REG_W-1:0]      issue_data_reg_i,
  input  logic [REG_W-1:0]      issue_weight_reg_i,
  input  logic [REG_W-1:0]      issue_acc_reg_i,
  input  logic [CTRL_WIDTH-1:0] issue_ctrl_i,
  input  logic [ID_WIDTH-1:0]   issue_id_i,
  input  logic                  flush_i,
  input  logic                  sa_ready_i,
  output logic                  start_o,
  output logic [REG_W-1:0]      data_reg_o,
  output logic [REG_W-1:0]      weight_reg_o,
  output logic [REG_W-1:0]      acc_reg_o,
  output logic [CTRL_WIDTH-1:0] sa_ctrl_o,
  output logic [ID_WIDTH-1:0]   id_o,
  input  logic                  finished_i,
  input  logic [ID_WIDTH-1:0]   finished_id_i,
  output logic                  finished_ack_o,
  output logic                  commit_valid_o,
  output logic [ID_WIDTH-1:0]   commit_id_o,
  input  logic                  commit_ready_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned SB_CW = $clog2(MAX_INFLIGHT + 1);
  localparam int unsigned SB_IW = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;

  typedef struct packed {
    logic [REG_W-1:0]      data_reg;
    logic [REG_W-1:0]      weight_reg;
    logic [REG_W-1:0]      acc_reg;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic [ID_WIDTH-1:0]   id;
  } entry_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_COMMIT = 1'b1
  } state_e;

  // Queue state
  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             empty, full, push, pop;
  entry_t           head, in_entry;

  // Scoreboard state
  logic [MAX_INFLIGHT-1:0] sb_valid_q, sb_valid_d;
  logic [REG_W-1:0]        sb_acc_q [MAX_INFLIGHT];
  logic [REG_W-1:0]        sb_acc_d [MAX_INFLIGHT];
  logic [ID_WIDTH-1:0]     sb_id_q  [MAX_INFLIGHT];
  logic [ID_WIDTH-1:0]     sb_id_d  [MAX_INFLIGHT];
  logic [SB_CW-1:0]        sb_cnt_q, sb_cnt_d;
  logic                    hazard, sb_full;
  logic [SB_IW-1:0]        free_idx, match_idx;
  logic                    match_found;

  // Completion FSM state
  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] commit_id_q, commit_id_d;
  logic                err_q, err_d;
  logic                ack, retire;

  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));
  assign in_entry = '{data_reg:   issue_data_reg_i,
                      weight_reg: issue_weight_reg_i,
                      acc_reg:    issue_acc_reg_i,
                      ctrl:       issue_ctrl_i,
                      id:         issue_id_i};
  assign head     = empty ? '0 : mem_q[rd_ptr_q];
  assign sb_full  = (sb_cnt_q == SB_CW'(MAX_INFLIGHT));

  assign issue_ready_o = !full;
  assign push          = issue_valid_i && issue_ready_o && !flush_i;
  assign start_o       = !empty && sa_ready_i && !hazard && !sb_full && !flush_i;
  assign pop           = start_o;
  assign retire        = ack && match_found;

  assign data_reg_o     = head.data_reg;
  assign weight_reg_o   = head.weight_reg;
  assign acc_reg_o      = head.acc_reg;
  assign sa_ctrl_o      = head.ctrl;
  assign id_o           = head.id;
  assign finished_ack_o = ack;
  assign commit_valid_o = (state_q == ST_COMMIT);
  assign commit_id_o    = commit_id_q;
  assign err_o          = err_q;
  assign busy_o         = !empty || (sb_cnt_q != '0) || (state_q == ST_COMMIT);

  // Queue storage; payload needs no reset since head is masked when empty
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= in_entry;
  end

  // Queue pointer/count next state; flush drops everything not yet dispatched
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Hazard detect plus lowest free / lowest matching slot search (downward scan, last hit wins)
  always_comb begin
    hazard      = 1'b0;
    free_idx    = '0;
    match_idx   = '0;
    match_found = 1'b0;
    for (int i = int'(MAX_INFLIGHT) - 1; i >= 0; i--) begin
      if (sb_valid_q[i]) begin
        if (sb_acc_q[i] == head.data_reg || sb_acc_q[i] == head.weight_reg ||
            sb_acc_q[i] == head.acc_reg) begin
          hazard = 1'b1;
        end
        if (sb_id_q[i] == finished_id_i) begin
          match_found = 1'b1;
          match_idx   = SB_IW'(i);
        end
      end else begin
        free_idx = SB_IW'(i);
      end
    end
  end

  // Scoreboard update: allocate on dispatch, release on acknowledged completion
  always_comb begin
    sb_valid_d = sb_valid_q;
    sb_acc_d   = sb_acc_q;
    sb_id_d    = sb_id_q;
    sb_cnt_d   = sb_cnt_q;
    if (retire) sb_valid_d[match_idx] = 1'b0;
    if (start_o) begin
      sb_valid_d[free_idx] = 1'b1;
      sb_acc_d[free_idx]   = head.acc_reg;
      sb_id_d[free_idx]    = head.id;
    end
    case ({start_o, retire})
      2'b10:   sb_cnt_d = sb_cnt_q + SB_CW'(1);
      2'b01:   sb_cnt_d = sb_cnt_q - SB_CW'(1);
      default: sb_cnt_d = sb_cnt_q;
    endcase
  end

  // Completion FSM: ack once, then hold the commit until the core takes it
  always_comb begin
    state_d     = state_q;
    ack         = 1'b0;
    commit_id_d = commit_id_q;
    err_d       = err_q;
    case (state_q)
      ST_IDLE: begin
        if (finished_i) begin
          ack         = 1'b1;
          state_d     = ST_COMMIT;
          commit_id_d = finished_id_i;
          if (!match_found) err_d = 1'b1;
        end
      end
      ST_COMMIT: begin
        if (commit_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      sb_valid_q  <= '0;
      sb_cnt_q    <= '0;
      state_q     <= ST_IDLE;
      commit_id_q <= '0;
      err_q       <= 1'b0;
      for (int i = 0; i < int'(MAX_INFLIGHT); i++) begin
        sb_acc_q[i] <= '0;
        sb_id_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      sb_valid_q  <= sb_valid_d;
      sb_cnt_q    <= sb_cnt_d;
      state_q     <= state_d;
      commit_id_q <= commit_id_d;
      err_q       <= err_d;
      sb_acc_q    <= sb_acc_d;
      sb_id_q     <= sb_id_d;
    end
  end

endmodule

// File: tb/tb_sa_dispatcher.sv
// Bench for sa_dispatcher: cycle table, directed corner sequences, and a
// randomized run checked against a queue-based reference model.
module tb_sa_dispatcher;

  typedef struct packed {
    logic       iv;
    logic [2:0] d, w, a;
    logic [3:0] c, id;
    logic       fl, sar, fin;
    logic [3:0] fid;
    logic       cr;
  } stim_t;

  typedef struct packed {
    logic       ir, st;
    logic [2:0] d, w, a;
    logic [3:0] c, id;
    logic       ack, cv;
    logic [3:0] cid;
    logic       busy, err;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } vec_t;

  typedef struct packed {
    logic [2:0] d, w, a;
    logic [3:0] c, id;
  } ent_t;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       issue_valid_i, issue_ready_o;
  logic [2:0] issue_data_reg_i, issue_weight_reg_i, issue_acc_reg_i;
  logic [3:0] issue_ctrl_i, issue_id_i;
  logic       flush_i, sa_ready_i, start_o;
  logic [2:0] data_reg_o, weight_reg_o, acc_reg_o;
  logic [3:0] sa_ctrl_o, id_o;
  logic       finished_i;
  logic [3:0] finished_id_i;
  logic       finished_ack_o, commit_valid_o;
  logic [3:0] commit_id_o;
  logic       commit_ready_i, busy_o, err_o;

  int total = 0;
  int bad   = 0;

  always #5 clk_i = ~clk_i;

  sa_dispatcher #(
    .N_REGS(8), .ID_WIDTH(4), .CTRL_WIDTH(4), .DEPTH(4), .MAX_INFLIGHT(3)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
    .issue_data_reg_i(issue_data_reg_i), .issue_weight_reg_i(issue_weight_reg_i),
    .issue_acc_reg_i(issue_acc_reg_i), .issue_ctrl_i(issue_ctrl_i), .issue_id_i(issue_id_i),
    .flush_i(flush_i), .sa_ready_i(sa_ready_i), .start_o(start_o),
    .data_reg_o(data_reg_o), .weight_reg_o(weight_reg_o), .acc_reg_o(acc_reg_o),
    .sa_ctrl_o(sa_ctrl_o), .id_o(id_o),
    .finished_i(finished_i), .finished_id_i(finished_id_i), .finished_ack_o(finished_ack_o),
    .commit_valid_o(commit_valid_o), .commit_id_o(commit_id_o), .commit_ready_i(commit_ready_i),
    .busy_o(busy_o), .err_o(err_o)
  );

  // Reference model state
  ent_t       mq[$];
  logic       sv_m [3];
  logic [2:0] sa_m [3];
  logic [3:0] sid_m[3];
  logic       pend_m;
  logic [3:0] pid_m;
  logic       err_m;
  logic [3:0] pool[$];

  vec_t tbl[11];

  function automatic stim_t mk_s(int iv, int d, int w, int a, int c, int id,
                                 int fl, int sar, int fin, int fid, int cr);
    stim_t s;
    s.iv = 1'(iv); s.d = 3'(d); s.w = 3'(w); s.a = 3'(a); s.c = 4'(c); s.id = 4'(id);
    s.fl = 1'(fl); s.sar = 1'(sar); s.fin = 1'(fin); s.fid = 4'(fid); s.cr = 1'(cr);
    return s;
  endfunction

  function automatic exp_t mk_e(int ir, int st, int d, int w, int a, int c, int id,
                                int ack, int cv, int cid, int busy, int err);
    exp_t e;
    e.ir = 1'(ir); e.st = 1'(st); e.d = 3'(d); e.w = 3'(w); e.a = 3'(a); e.c = 4'(c);
    e.id = 4'(id); e.ack = 1'(ack); e.cv = 1'(cv); e.cid = 4'(cid);
    e.busy = 1'(busy); e.err = 1'(err);
    return e;
  endfunction

  function automatic exp_t actual();
    exp_t a;
    a.ir = issue_ready_o; a.st = start_o; a.d = data_reg_o; a.w = weight_reg_o;
    a.a = acc_reg_o; a.c = sa_ctrl_o; a.id = id_o; a.ack = finished_ack_o;
    a.cv = commit_valid_o; a.cid = commit_id_o; a.busy = busy_o; a.err = err_o;
    return a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input stim_t s);
    issue_valid_i = s.iv; issue_data_reg_i = s.d; issue_weight_reg_i = s.w;
    issue_acc_reg_i = s.a; issue_ctrl_i = s.c; issue_id_i = s.id;
    flush_i = s.fl; sa_ready_i = s.sar; finished_i = s.fin;
    finished_id_i = s.fid; commit_ready_i = s.cr;
  endtask

  task automatic advance();
    @(posedge clk_i);
    #1;
  endtask

  // Present a completion and wait (bounded) for its ack, then let the commit drain
  task automatic retire(input int id);
    bit seen = 1'b0;
    apply(mk_s(0, 0, 0, 0, 0, 0, 0, 1, 1, id, 1));
    for (int c = 0; c < 10 && !seen; c++) begin
      @(negedge clk_i);
      seen = finished_ack_o;
      advance();
    end
    finished_i = 1'b0;
    check("retire ack", 32'(seen), 1);
    advance();
  endtask

  function automatic void model_reset();
    mq.delete();
    pool.delete();
    for (int i = 0; i < 3; i++) begin
      sv_m[i] = 1'b0; sa_m[i] = '0; sid_m[i] = '0;
    end
    pend_m = 1'b0; pid_m = '0; err_m = 1'b0;
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    ent_t h;
    int   n  = 0;
    bit   hz = 1'b0;
    h = (mq.size() > 0) ? mq[0] : '0;
    for (int i = 0; i < 3; i++) begin
      if (sv_m[i]) begin
        n++;
        if (sa_m[i] == h.d || sa_m[i] == h.w || sa_m[i] == h.a) hz = 1'b1;
      end
    end
    e.ir   = (mq.size() < 4);
    e.st   = (mq.size() > 0) && sa_ready_i && !hz && (n < 3) && !flush_i;
    e.d    = h.d; e.w = h.w; e.a = h.a; e.c = h.c; e.id = h.id;
    e.ack  = !pend_m && finished_i;
    e.cv   = pend_m;
    e.cid  = pid_m;
    e.busy = (mq.size() > 0) || (n > 0) || pend_m;
    e.err  = err_m;
    return e;
  endfunction

  function automatic void model_step(input exp_t e);
    int   fr = -1;
    int   mt = -1;
    ent_t ni;
    for (int i = 0; i < 3; i++) begin
      if (!sv_m[i] && fr < 0) fr = i;
      if (sv_m[i] && sid_m[i] == finished_id_i && mt < 0) mt = i;
    end
    if (e.ack) begin
      if (mt >= 0) sv_m[mt] = 1'b0;
      else err_m = 1'b1;
      pend_m = 1'b1;
      pid_m  = finished_id_i;
    end else if (pend_m && commit_ready_i) begin
      pend_m = 1'b0;
    end
    if (e.st && fr >= 0) begin
      pool.push_back(mq[0].id);
      sv_m[fr] = 1'b1; sa_m[fr] = mq[0].a; sid_m[fr] = mq[0].id;
      void'(mq.pop_front());
    end
    if (flush_i) mq.delete();
    else if (issue_valid_i && e.ir) begin
      ni.d = issue_data_reg_i; ni.w = issue_weight_reg_i; ni.a = issue_acc_reg_i;
      ni.c = issue_ctrl_i; ni.id = issue_id_i;
      mq.push_back(ni);
    end
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] got[$];
    bit         issued, drop;
    exp_t       e;

    // Cycle table: dispatch latency, head fields, RAW stall until ack, commit handshake
    tbl[0]  = '{mk_s(1,1,2,3,6,5, 0,1,0,0,0), mk_e(1,0, 0,0,0,0,0, 0,0,0,0,0)};
    tbl[1]  = '{mk_s(0,0,0,0,0,0, 0,1,0,0,0), mk_e(1,1, 1,2,3,6,5, 0,0,0,1,0)};
    tbl[2]  = '{mk_s(1,0,1,3,1,6, 0,1,0,0,0), mk_e(1,0, 0,0,0,0,0, 0,0,0,1,0)};
    tbl[3]  = '{mk_s(0,0,0,0,0,0, 0,1,0,0,0), mk_e(1,0, 0,1,3,1,6, 0,0,0,1,0)};
    tbl[4]  = '{mk_s(0,0,0,0,0,0, 0,1,1,5,0), mk_e(1,0, 0,1,3,1,6, 1,0,0,1,0)};
    tbl[5]  = '{mk_s(0,0,0,0,0,0, 0,1,0,0,0), mk_e(1,1, 0,1,3,1,6, 0,1,5,1,0)};
    tbl[6]  = '{mk_s(0,0,0,0,0,0, 0,1,0,0,1), mk_e(1,0, 0,0,0,0,0, 0,1,5,1,0)};
    tbl[7]  = '{mk_s(0,0,0,0,0,0, 0,0,0,0,0), mk_e(1,0, 0,0,0,0,0, 0,0,5,1,0)};
    tbl[8]  = '{mk_s(0,0,0,0,0,0, 0,0,1,6,0), mk_e(1,0, 0,0,0,0,0, 1,0,5,1,0)};
    tbl[9]  = '{mk_s(0,0,0,0,0,0, 0,0,0,0,1), mk_e(1,0, 0,0,0,0,0, 0,1,6,1,0)};
    tbl[10] = '{mk_s(0,0,0,0,0,0, 0,0,0,0,0), mk_e(1,0, 0,0,0,0,0, 0,0,6,0,0)};

    apply(mk_s(0,0,0,0,0,0, 0,0,0,0,0));
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("reset hold", 32'(actual()), 32'(mk_e(1,0, 0,0,0,0,0, 0,0,0,0,0)));
    rst_ni = 1'b1;
    @(negedge clk_i);
    check("reset state", 32'(actual()), 32'(mk_e(1,0, 0,0,0,0,0, 0,0,0,0,0)));
    advance();

    for (int i = 0; i < 11; i++) begin
      apply(tbl[i].s);
      @(negedge clk_i);
      check($sformatf("table row %0d", i), 32'(actual()), 32'(tbl[i].e));
      advance();
    end

    // Fill the queue with the array stalled; fifth issue must be refused
    for (int k = 0; k < 4; k++) begin
      apply(mk_s(1, 4, 5, k, k, 8 + k, 0, 0, 0, 0, 1));
      @(negedge clk_i);
      check("fill ready", 32'(issue_ready_o), 1);
      advance();
    end
    apply(mk_s(1, 4, 5, 3, 0, 12, 0, 0, 0, 0, 1));
    @(negedge clk_i);
    check("full refuse", 32'(issue_ready_o), 0);
    check("full head id", 32'(id_o), 8);
    advance();
    apply(mk_s(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    issued = 1'b0;
    drop   = 1'b0;
    for (int c = 0; c < 30 && got.size() < 4; c++) begin
      @(negedge clk_i);
      if (start_o) got.push_back(id_o);
      drop = finished_ack_o;
      advance();
      if (drop) finished_i = 1'b0;
      if (got.size() == 3 && !issued) begin
        finished_i = 1'b1; finished_id_i = 4'd8; issued = 1'b1;
      end
    end
    check("drain count", 32'(got.size()), 4);
    for (int i = 0; i < got.size(); i++) check("drain order", 32'(got[i]), 8 + i);
    finished_i = 1'b0;
    advance();
    retire(9); retire(10); retire(11);
    @(negedge clk_i);
    check("drain idle", 32'(busy_o), 0);
    advance();

    // Three independent dispatches fill the scoreboard; the fourth waits for a retire
    for (int k = 0; k < 4; k++) begin
      apply(mk_s(1, 5, 6, (k == 3) ? 4 : k, 0, k + 1, 0, 1, 0, 0, 1));
      @(negedge clk_i);
      check("pipe start", 32'(start_o), (k > 0) ? 1 : 0);
      if (k > 0) check("pipe id", 32'(id_o), k);
      advance();
    end
    apply(mk_s(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check("sbfull stall", 32'(start_o), 0);
      check("sbfull head", 32'(id_o), 4);
      advance();
    end
    apply(mk_s(0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1));
    @(negedge clk_i);
    check("retire ack cycle", 32'(finished_ack_o), 1);
    check("same-cycle retire", 32'(start_o), 0);
    advance();
    finished_i = 1'b0;
    @(negedge clk_i);
    check("unblock start", 32'(start_o), 1);
    check("unblock id", 32'(id_o), 4);
    advance();
    retire(2); retire(3); retire(4);

    // Unknown completion ID: sticky error, commit held, no second ack while pending
    apply(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 0));
    @(negedge clk_i);
    check("unk ack", 32'(finished_ack_o), 1);
    check("unk err pre", 32'(err_o), 0);
    advance();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      check("hold state", 32'({finished_ack_o, commit_valid_o, commit_id_o, err_o}), 32'({1'b0, 1'b1, 4'd9, 1'b1}));
      advance();
    end
    apply(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    @(negedge clk_i);
    check("unk commit", 32'(commit_valid_o), 1);
    advance();
    @(negedge clk_i);
    check("err sticky", 32'({commit_valid_o, err_o}), 32'({1'b0, 1'b1}));
    advance();

    // Flush with two queued entries while one instruction is in flight
    apply(mk_s(1, 0, 0, 7, 0, 3, 0, 1, 0, 0, 1));
    advance();
    apply(mk_s(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    @(negedge clk_i);
    check("flush pre start", 32'(start_o), 1);
    advance();
    apply(mk_s(1, 2, 2, 1, 0, 4, 0, 0, 0, 0, 1));
    advance();
    apply(mk_s(1, 2, 2, 2, 0, 5, 0, 0, 0, 0, 1));
    advance();
    apply(mk_s(1, 1, 1, 1, 0, 6, 1, 1, 1, 3, 1));
    @(negedge clk_i);
    check("flush no start", 32'({start_o, id_o, finished_ack_o}), 32'({1'b0, 4'd4, 1'b1}));
    advance();
    apply(mk_s(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1));
    @(negedge clk_i);
    check("flush empty", 32'({start_o, id_o}), 0);
    check("flush commit", 32'({commit_valid_o, commit_id_o}), 32'({1'b1, 4'd3}));
    advance();
    @(negedge clk_i);
    check("flush idle", 32'(busy_o), 0);
    advance();

    // Randomized run against the reference model, with an asynchronous reset midway
    apply(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_ni = 1'b0;
    advance();
    rst_ni = 1'b1;
    model_reset();
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (cyc == 200) begin
        apply(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #2;
        rst_ni = 1'b0;
        #1;
        check("async reset", 32'(actual()), 32'(mk_e(1,0, 0,0,0,0,0, 0,0,0,0,0)));
        advance();
        rst_ni = 1'b1;
        model_reset();
      end
      issue_valid_i      = 1'($urandom_range(0, 1));
      issue_data_reg_i   = 3'($urandom);
      issue_weight_reg_i = 3'($urandom);
      issue_acc_reg_i    = 3'($urandom);
      issue_ctrl_i       = 4'($urandom);
      issue_id_i         = 4'($urandom);
      flush_i            = ($urandom_range(0, 15) == 0);
      sa_ready_i         = ($urandom_range(0, 3) != 0);
      commit_ready_i     = 1'($urandom_range(0, 1));
      if (!finished_i && $urandom_range(0, 2) == 0) begin
        if (pool.size() > 0 && $urandom_range(0, 7) != 0) begin
          int idx;
          idx = $urandom_range(0, pool.size() - 1);
          finished_id_i = pool[idx];
          pool.delete(idx);
        end else begin
          finished_id_i = 4'($urandom);
        end
        finished_i = 1'b1;
      end
      e = model_exp();
      @(negedge clk_i);
      check($sformatf("rand cyc %0d", cyc), 32'(actual()), 32'(e));
      model_step(e);
      advance();
      if (e.ack) finished_i = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sa_dispatcher.md
Name: sa_dispatcher

Overview:
- Sits between the matrix-instruction decode/issue stage and the systolic array.
- Buffers decoded matrix-multiply instructions in an in-order queue and dispatches each with a one-cycle start pulse when the array is ready.
- Tracks in-flight destination accumulators in a scoreboard so RAW/WAW hazards stall dispatch.
- Collects array completions, acknowledges them, and forwards ordered commit notifications to the core.

Parameters:
- N_REGS, 8, number of matrix registers; REG_W = $clog2(N_REGS).
- ID_WIDTH, 4, instruction ID width; must equal xif_pkg::X_ID_WIDTH.
- CTRL_WIDTH, 4, width of the SIMD/format control field passed to the array.
- DEPTH, 4, instruction queue entries; power of two, at least 2.
- MAX_INFLIGHT, 3, scoreboard entries (one per array stage: FF/FS/DR); at least 1.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- issue_valid_i  in  1  new instruction valid.
- issue_ready_o  out  1  queue can accept.
- issue_data_reg_i  in  REG_W  data source register.
- issue_weight_reg_i  in  REG_W  weight source register.
- issue_acc_reg_i  in  REG_W  accumulator source and destination register.
- issue_ctrl_i  in  CTRL_WIDTH  sa control field.
- issue_id_i  in  ID_WIDTH  instruction ID.
- flush_i  in  1  discard all queued, not-yet-dispatched instructions.
- sa_ready_i  in  1  array can accept start.
- start_o  out  1  dispatch pulse.
- data_reg_o  out  REG_W  head data register.
- weight_reg_o  out  REG_W  head weight register.
- acc_reg_o  out  REG_W  head accumulator register.
- sa_ctrl_o  out  CTRL_WIDTH  head control field.
- id_o  out  ID_WIDTH  head instruction ID.
- finished_i  in  1  array completion flag; held until acknowledged.
- finished_id_i  in  ID_WIDTH  ID of the completed instruction.
- finished_ack_o  out  1  completion acknowledge (one-cycle pulse).
- commit_valid_o  out  1  completion pending to core.
- commit_id_o  out  ID_WIDTH  completed instruction ID.
- commit_ready_i  in  1  core accepts commit.
- busy_o  out  1  queue non-empty, scoreboard non-empty, or commit pending.
- err_o  out  1  sticky: completion ID not found in scoreboard.

Behaviour:
- Reset values:
  - Queue empty, scoreboard cleared.
  - issue_ready_o=1; start_o, finished_ack_o, commit_valid_o, busy_o, err_o = 0.
  - commit_id_o=0; head field outputs 0.
- Reset is asynchronous at any point, including mid-dispatch: all state returns to reset values immediately.

Queue:
- Circular FIFO with registered pointers and a count of width $clog2(DEPTH)+1.
- issue_ready_o = !full, derived from registered state only. A full queue refuses a push even when a pop happens in the same cycle.
- Push when issue_valid_i & issue_ready_o.
- An entry pushed in cycle t is at the head no earlier than t+1. Minimum issue-to-start latency is 1 cycle.
- Head field outputs always reflect the head entry, or 0 when the queue is empty.

Dispatch:
- hazard: any valid scoreboard entry's dest equals head data_reg, weight_reg, or acc_reg.
- start_o = !empty & sa_ready_i & !hazard & !sb_full & !flush_i (combinational).
- start_o pops the head and writes {acc_reg, id} into a free scoreboard slot. The lowest-index free slot is used.
- Hazard and sb_full use the registered scoreboard. A slot retiring in the same cycle does not unblock dispatch until the next cycle.
- flush_i clears the queue next cycle. The scoreboard, commit path, and err_o are unaffected. flush_i with issue_valid_i in the same cycle drops the incoming instruction; issue_ready_o stays as computed.

Completion FSM, states IDLE and COMMIT:
- IDLE, finished_i=1:
  - finished_ack_o=1 for exactly one cycle.
  - Capture commit_id_o=finished_id_i and go to COMMIT.
  - Invalidate the matching scoreboard entry. If several entries match, invalidate the lowest index.
  - If none matches, set err_o (sticky until reset); commit still proceeds.
- COMMIT:
  - commit_valid_o=1 and finished_ack_o=0.
  - On commit_ready_i, go to IDLE. A new finished_i is acked no earlier than the following cycle.
- commit_valid_o and commit_id_o are registered and stay stable until accepted.
- Dispatch and retire in the same cycle are both applied, and the scoreboard count stays consistent (+1 and -1).
- Scoreboard count never exceeds MAX_INFLIGHT; sb_full = count==MAX_INFLIGHT.

Test Plan:
1. Issue A (data=1, weight=2, acc=3, id=5) with sa_ready_i=1 -> start_o at the next cycle with fields 1/2/3/ctrl/5; issue_ready_o stays 1; busy_o=1.
2. Dispatch A (acc=3), then issue B with acc=3 -> start_o stays 0 until finished_i (id=5) is acked; B's start_o is the cycle after finished_ack_o.
3. Fill the queue with 4 instructions while sa_ready_i=0 -> issue_ready_o=0 on the 5th valid, which is not accepted. Raise sa_ready_i -> 4 starts in order, ids preserved.
4. Dispatch 3 independent instructions (acc 0, 1, 2), then a 4th with acc=4 -> stalled by sb_full. Retire id of acc 0 -> 4th starts the cycle after the ack.
5. finished_i with id 9, not in scoreboard -> finished_ack_o pulses, err_o=1 and stays 1, commit_valid_o=1 with commit_id_o=9. Hold commit_ready_i=0 for 3 cycles -> no further ack despite finished_i=1.
6. Queue holds 2 entries; assert flush_i with sa_ready_i=1 -> no start_o; queue empty next cycle; in-flight completion still commits.
